// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and common baud constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int CLKS_PER_BIT_9600_100M = 10416;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Valid/ready holding-register handshake between the UART receive path and its consumer.
interface uart_rx_controller_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_controller_baud.sv
// Restartable down-counter; tick marks the cycle in which the count has reached zero.
module baud_tick_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = load ? load_val : cnt_q - CNT_W'(1);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start-edge detection, mid-bit sampling, frame shift-in and
// delivery through a valid/ready holding register with frame-error and overrun pulses.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_100M,
    parameter int DATA_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    uart_rx_controller_if.master        rx_if,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic                 rx_meta_q, rx_s_q, rx_s_d_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_q;

    logic                 start_edge, tick, load;
    logic [CNT_W-1:0]     load_val;

    // rx is asynchronous to clk; the idle-high reset value avoids a phantom start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
        end
    end

    assign start_edge = !rx_s_q && rx_s_d_q;

    // IDLE pins the counter at zero so each frame starts phase-aligned to its own start edge.
    // NOTE: every output of this block gets a default first, otherwise latches are inferred.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: begin
                load = 1'b1;
                if (start_edge) load_val = HALF_LOAD;
            end
            START: begin
                load = tick;
                if (!rx_s_q) load_val = BIT_LOAD;
            end
            DATA: begin
                load     = tick;
                load_val = BIT_LOAD;
            end
            STOP: begin
                load = tick;
            end
            default: ;
        endcase
    end

    baud_tick_counter #(.CNT_W(CNT_W)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (rx_valid_q && rx_if.rx_ready) rx_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_edge) state_q <= START;
                end
                START: begin
                    if (tick) begin
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q[bit_cnt_q] <= rx_s_q;
                        bit_cnt_q          <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        if (!rx_s_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!rx_valid_q || rx_if.rx_ready) begin
                            // Later assignment overrides the accept-clear above: accept-and-replace.
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: 16 clk/bit 8N1 frames, scoreboard on accepted bytes.
module tb_uart_rx_controller;

    localparam int CPB       = 16;
    localparam int DBITS     = 8;
    localparam int FRAME_CYC = 10 * CPB;
    // Stop sample lands on edge 3 + CPB/2 + 9*CPB after the first edge that sees the start bit.
    localparam int STOP_C    = 3 + CPB / 2 + 9 * CPB - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic frame_err, overrun, busy;

    uart_rx_controller_if #(.DATA_BITS(DBITS)) rx_if ();

    uart_rx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_err;
    } vec_t;

    int         n_total = 0;
    int         n_pass  = 0;
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame bit-synchronously; optional one-cycle rx_ready pulse at cycle pulse_c.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int pulse_c, input int ncyc);
        logic [9:0] bits;
        logic       ready_save;
        bits       = {stop_bit, d, 1'b0};
        ready_save = rx_if.rx_ready;
        for (int c = 0; c < ncyc; c++) begin
            rx = bits[c / CPB];
            if (c == pulse_c) rx_if.rx_ready = 1'b1;
            else if (c == pulse_c + 1) rx_if.rx_ready = ready_save;
            @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    // Scoreboard monitor: pops on every accepted byte, counts error pulses, checks hold stability.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (prev_valid && !prev_ready && rx_if.rx_valid)
                check("hold_stable", rx_if.rx_data, prev_data);
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                check("queue_nonempty_at_accept", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rx_data", rx_if.rx_data, exp_q.pop_front());
            end
            prev_valid = rx_if.rx_valid;
            prev_ready = rx_if.rx_ready;
            prev_data  = rx_if.rx_data;
        end
    end

    vec_t vecs[6];
    int   fe0, ov0;

    initial begin
        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, exp_err: 1'b1};
        vecs[2] = '{data: 8'h81, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'h00, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[5] = '{data: 8'h5A, stop_bit: 1'b1, exp_err: 1'b0};

        rst_n          = 1'b0;
        rx             = 1'b1;
        rx_if.rx_ready = 1'b1;
        #2;
        check("reset_rx_valid", rx_if.rx_valid, 0);
        check("reset_rx_data", rx_if.rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // Table-driven frames, including 0xA5 and the framing-error 0x3C followed by 0x81.
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].exp_err) exp_q.push_back(vecs[i].data);
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit, -1, FRAME_CYC);
            idle(4);
            check("vec_frame_err", fe_cnt - fe0, {31'd0, vecs[i].exp_err});
            check("vec_overrun", ov_cnt - ov0, 0);
            check("vec_rx_valid_idle", rx_if.rx_valid, 0);
            check("vec_busy_idle", busy, 0);
            check("vec_queue_drained", exp_q.size(), 0);
        end

        // False start: a 5-cycle low glitch is rejected at the half-bit sample.
        fe0 = fe_cnt;
        rx  = 1'b0;
        idle(5);
        check("glitch_busy", busy, 1);
        rx = 1'b1;
        idle(20);
        check("glitch_busy_after", busy, 0);
        check("glitch_rx_valid", rx_if.rx_valid, 0);
        check("glitch_frame_err", fe_cnt - fe0, 0);

        // Overrun: 0x11 held while 0x22 arrives, then accepted.
        rx_if.rx_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, FRAME_CYC);
        idle(2);
        send_frame(8'h22, 1'b1, -1, FRAME_CYC);
        idle(2);
        check("ovr_overrun", ov_cnt - ov0, 1);
        check("ovr_rx_valid", rx_if.rx_valid, 1);
        check("ovr_rx_data", rx_if.rx_data, 8'h11);
        rx_if.rx_ready = 1'b1;
        idle(2);
        check("ovr_rx_valid_fall", rx_if.rx_valid, 0);
        check("ovr_queue_drained", exp_q.size(), 0);

        // Accept-and-replace: rx_ready pulses on the stop-tick cycle of the second frame.
        rx_if.rx_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, FRAME_CYC);
        idle(2);
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, STOP_C, FRAME_CYC);
        idle(2);
        check("rep_overrun", ov_cnt - ov0, 0);
        check("rep_rx_valid", rx_if.rx_valid, 1);
        check("rep_rx_data", rx_if.rx_data, 8'h66);
        check("rep_queue_one_left", exp_q.size(), 1);
        rx_if.rx_ready = 1'b1;
        idle(2);
        check("rep_queue_drained", exp_q.size(), 0);

        // Asynchronous reset during DATA bit 3 of 0xF0, with 0x33 still held.
        rx_if.rx_ready = 1'b0;
        send_frame(8'h33, 1'b1, -1, FRAME_CYC);
        idle(2);
        check("rst_pending_valid", rx_if.rx_valid, 1);
        check("rst_pending_data", rx_if.rx_data, 8'h33);
        send_frame(8'hF0, 1'b1, -1, 3 + CPB / 2 + 3 * CPB + CPB / 2);
        check("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        check("rst_rx_valid", rx_if.rx_valid, 0);
        check("rst_rx_data", rx_if.rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        idle(3);
        rst_n          = 1'b1;
        rx_if.rx_ready = 1'b1;
        idle(4);
        fe0 = fe_cnt;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, FRAME_CYC);
        idle(4);
        check("post_rst_queue_drained", exp_q.size(), 0);
        check("post_rst_frame_err", fe_cnt - fe0, 0);
        check("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
